fixed_order_arbiter_requester: RTL and testbench
================================================

Name: fixed_order_arbiter_requester

Overview:
- Requester-side agent for the 4-way fixed-order arbiter. It turns per-channel job pulses into level requests (req) and drives the arbiter's enable. It consumes the one-hot grant, retiring one job per grant.
- Tracks outstanding jobs per channel with saturating counters. Flags grant-protocol violations and channel starvation. Sits between job producers and the arbiter's req/enable/grant interface.

Parameters:
- N, 4, number of channels (width of req/grant).
- CNT_W, 3, width of each per-channel outstanding-job counter. Maximum outstanding per channel is 2^CNT_W-1.
- TIMEOUT, 16, cycles a request may wait ungranted before starve is flagged; must be < 2^WAIT_W.
- WAIT_W, 5, width of each per-channel wait counter.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- run  input  1  request to let the arbiter run.
- job_in  input  N  per-channel single-cycle job pulse; bit i adds one job to channel i.
- grant  input  N  grant from arbiter; one-hot or zero; bit i retires one job of channel i.
- req  output  N  level request to arbiter; req[i]=1 iff channel i has outstanding jobs.
- enable  output  1  arbiter enable, registered copy of run.
- pending  output  N*CNT_W  packed outstanding counts, channel i at [i*CNT_W +: CNT_W].
- drop_err  output  N  sticky: job_in[i] arrived while channel i was saturated and not granted.
- grant_err  output  1  sticky: grant multi-hot, or grant[i] with req[i]=0 or enable=0.
- starve  output  N  sticky: channel i waited TIMEOUT consecutive cycles with req[i]=1 and no grant[i].
- served  output  16  total valid grants accepted; wraps 0xFFFF->0.

Behaviour:
- Reset (rst=1 at an edge) clears every counter and sticky bit. After reset: req=0, enable=0, pending=0, drop_err=0, grant_err=0, starve=0, served=0.
- Reset mid-operation discards all outstanding jobs. job_in and grant in the reset cycle are ignored.
- enable <= run each cycle, one-cycle latency.
- Valid grant on channel i: grant[i]=1, grant is one-hot, req[i]=1 and enable=1 in the same cycle.
- Counter update for channel i, per edge:
  - job only: cnt+1, unless cnt is at max; then hold and set drop_err[i].
  - valid grant only: cnt-1.
  - job and valid grant in the same cycle: cnt unchanged, no drop even at max.
  - neither: hold.
- req[i] is combinational from registered state: (cnt_i != 0).
  - req rises the cycle after the first job_in.
  - req falls the cycle after the grant that retires the last job.
- Invalid grant (multi-hot, to a channel with req=0, or while enable=0): sets grant_err. No counter changes, no served increment, on any channel for that cycle.
- served increments by 1 per valid grant.
- Wait counter per channel:
  - clears on a valid grant[i] or when req[i]=0.
  - otherwise increments, saturating at TIMEOUT.
  - starve[i] sets on the edge the wait counter reaches TIMEOUT.
  - while enable=0 the wait counter holds; it neither counts nor clears.
- Sticky bits clear only on rst.
- Requests are held while enable=0. Jobs still accumulate; no grants are expected.

Test Plan:
- Reset then idle: rst 2 cycles, run=1, no jobs -> req=0, enable=1 one cycle after run, all flags 0, served=0.
- Basic cycle: job_in=4'b1011 one cycle, then arbiter grants 0001, 0010, 1000 on successive cycles -> req=1011, 1010, 1000, 0000; served=3; pending all 0.
- Saturation: 8 job_in[2] pulses with enable=0 -> pending ch2=7, drop_err=4'b0100. Then one cycle with job_in[2]=1 and grant=0100 while enable=1 -> ch2 stays 7, no new drop.
- Protocol errors: grant=4'b0011, then grant=4'b0100 with req[2]=0 -> grant_err=1, pending and served unchanged; flag persists until rst.
- Starvation: req[3] held with no grant[3] for 16 enabled cycles -> starve=4'b1000 on the 16th edge. Channel 3 wait does not advance while enable=0.
- Reset mid-operation: pending ch0=3, ch1=2, assert rst one cycle -> next cycle req=0, pending=0, served=0, flags cleared.

Source files
------------

// File: rtl/fixed_order_arbiter_requester.sv
// Requester-side agent for the 4-way fixed-order arbiter: turns job pulses into level
// requests, retires one job per valid grant, and flags drops, protocol errors and starvation.
module fixed_order_arbiter_requester #(
    parameter int N       = 4,
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = 16,
    parameter int WAIT_W  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    input  logic [N-1:0]         job_in,
    input  logic [N-1:0]         grant,
    output logic [N-1:0]         req,
    output logic                 enable,
    output logic [N*CNT_W-1:0]   pending,
    output logic [N-1:0]         drop_err,
    output logic                 grant_err,
    output logic [N-1:0]         starve,
    output logic [15:0]          served
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT);

    logic [CNT_W-1:0]  cnt      [N];
    logic [WAIT_W-1:0] wait_cnt [N];

    logic          grant_onehot;
    logic          grant_valid;
    logic [N-1:0]  vgrant;

    for (genvar g = 0; g < N; g++) begin : g_chan
        assign req[g]                     = (cnt[g] != '0);
        assign pending[g*CNT_W +: CNT_W]  = cnt[g];
    end

    // A grant is honoured only as a whole: one-hot, aimed at a requesting channel, while enabled.
    assign grant_onehot = (grant != '0) && ((grant & (grant - N'(1))) == '0);
    assign grant_valid  = grant_onehot && enable && ((grant & req) != '0);
    assign vgrant       = grant_valid ? grant : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            enable    <= 1'b0;
            drop_err  <= '0;
            grant_err <= 1'b0;
            starve    <= '0;
            served    <= '0;
            for (int i = 0; i < N; i++) begin
                cnt[i]      <= '0;
                wait_cnt[i] <= '0;
            end
        end else begin
            enable <= run;

            if ((grant != '0) && !grant_valid)
                grant_err <= 1'b1;

            if (grant_valid)
                served <= served + 16'd1;

            for (int i = 0; i < N; i++) begin
                // A job arriving together with its retiring grant nets out, even when full.
                case ({job_in[i], vgrant[i]})
                    2'b10: begin
                        if (cnt[i] == CNT_MAX)
                            drop_err[i] <= 1'b1;
                        else
                            cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                    2'b01:   cnt[i] <= cnt[i] - CNT_W'(1);
                    default: cnt[i] <= cnt[i];
                endcase

                // Waiting is only measured while the arbiter is allowed to run.
                if (enable) begin
                    if (vgrant[i] || !req[i]) begin
                        wait_cnt[i] <= '0;
                    end else if (wait_cnt[i] != WAIT_LIM) begin
                        wait_cnt[i] <= wait_cnt[i] + WAIT_W'(1);
                        if (wait_cnt[i] == WAIT_LIM - WAIT_W'(1))
                            starve[i] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fixed_order_arbiter_requester.sv
// Directed and randomized bench for fixed_order_arbiter_requester against a per-cycle
// behavioural model built from integer job counts and wait tallies.
module tb_fixed_order_arbiter_requester;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic [3:0]  job_in = '0;
    logic [3:0]  grant  = '0;
    logic [3:0]  req;
    logic        enable;
    logic [11:0] pending;
    logic [3:0]  drop_err;
    logic        grant_err;
    logic [3:0]  starve;
    logic [15:0] served;

    int checks = 0;
    int errors = 0;

    // Reference state: plain integers, not the RTL's encoding.
    int  m_cnt  [4];
    int  m_wait [4];
    bit  m_en;
    bit  [3:0] m_drop;
    bit  [3:0] m_starve;
    bit  m_gerr;
    int  m_served;

    fixed_order_arbiter_requester #(.N(4), .CNT_W(3), .TIMEOUT(16), .WAIT_W(5)) dut (
        .clk(clk), .rst(rst), .run(run), .job_in(job_in), .grant(grant),
        .req(req), .enable(enable), .pending(pending), .drop_err(drop_err),
        .grant_err(grant_err), .starve(starve), .served(served)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [3:0]  e_req;
        logic [11:0] e_pend;
        for (int i = 0; i < 4; i++) begin
            e_req[i]          = (m_cnt[i] != 0);
            e_pend[i*3 +: 3]  = 3'(m_cnt[i]);
        end
        chk("req",       32'(req),       32'(e_req));
        chk("enable",    32'(enable),    32'(m_en));
        chk("pending",   32'(pending),   32'(e_pend));
        chk("drop_err",  32'(drop_err),  32'(m_drop));
        chk("grant_err", 32'(grant_err), 32'(m_gerr));
        chk("starve",    32'(starve),    32'(m_starve));
        chk("served",    32'(served),    32'(m_served));
    endtask

    // Apply one cycle of inputs, advance the model by the specified rules, then compare.
    task automatic cyc(input logic r, input logic [3:0] j, input logic [3:0] g, input logic ru);
        int idx;
        bit valid;
        bit gi;
        rst = r; job_in = j; grant = g; run = ru;
        if (r) begin
            for (int i = 0; i < 4; i++) begin
                m_cnt[i] = 0;
                m_wait[i] = 0;
            end
            m_en = 0; m_drop = '0; m_starve = '0; m_gerr = 0; m_served = 0;
        end else begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (g[i]) idx = i;
            valid = ($countones(g) == 1) && m_en && (m_cnt[idx] > 0);
            if ((g != 0) && !valid) m_gerr = 1;
            if (valid) m_served = (m_served + 1) % 65536;
            for (int i = 0; i < 4; i++) begin
                gi = valid && (idx == i);
                if (m_en) begin
                    if (gi || m_cnt[i] == 0) begin
                        m_wait[i] = 0;
                    end else if (m_wait[i] < 16) begin
                        m_wait[i] = m_wait[i] + 1;
                        if (m_wait[i] == 16) m_starve[i] = 1;
                    end
                end
                if (j[i] && !gi) begin
                    if (m_cnt[i] == 7) m_drop[i] = 1;
                    else m_cnt[i] = m_cnt[i] + 1;
                end else if (gi && !j[i]) begin
                    m_cnt[i] = m_cnt[i] - 1;
                end
            end
            m_en = ru;
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        int q[$];
        logic [3:0] g;
        logic [3:0] j;

        // Reset then idle
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(1, 4'b0000, 4'b0000, 0);
        chk("rst_req", 32'(req), 32'h0);
        chk("rst_served", 32'(served), 32'h0);
        cyc(0, 4'b0000, 4'b0000, 1);
        chk("idle_enable", 32'(enable), 32'h1);

        // Basic request/grant cycle
        cyc(0, 4'b1011, 4'b0000, 1);
        chk("basic_req0", 32'(req), 32'hB);
        cyc(0, 4'b0000, 4'b0001, 1);
        chk("basic_req1", 32'(req), 32'hA);
        cyc(0, 4'b0000, 4'b0010, 1);
        chk("basic_req2", 32'(req), 32'h8);
        cyc(0, 4'b0000, 4'b1000, 1);
        chk("basic_req3", 32'(req), 32'h0);
        chk("basic_served", 32'(served), 32'd3);
        chk("basic_pending", 32'(pending), 32'h0);

        // Saturation with the arbiter disabled, then job+grant at max
        cyc(0, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 8; k++) cyc(0, 4'b0100, 4'b0000, 0);
        chk("sat_cnt2", 32'(pending[8:6]), 32'd7);
        chk("sat_drop", 32'(drop_err), 32'h4);
        cyc(0, 4'b0000, 4'b0000, 1);
        cyc(0, 4'b0100, 4'b0100, 1);
        chk("sat_hold_cnt2", 32'(pending[8:6]), 32'd7);
        chk("sat_no_new_drop", 32'(drop_err), 32'h4);
        chk("sat_served", 32'(served), 32'd4);

        // Protocol errors: grant to idle channel, multi-hot, grant while disabled
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0000, 4'b0000, 1);
        cyc(0, 4'b0000, 4'b0100, 1);
        chk("gerr_noreq", 32'(grant_err), 32'h1);
        chk("gerr_noreq_served", 32'(served), 32'h0);
        cyc(0, 4'b0000, 4'b0000, 1);
        chk("gerr_sticky", 32'(grant_err), 32'h1);
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0011, 4'b0000, 1);
        cyc(0, 4'b0000, 4'b0011, 1);
        chk("gerr_multihot", 32'(grant_err), 32'h1);
        chk("gerr_multihot_pend", 32'(pending), 32'h009);
        chk("gerr_multihot_served", 32'(served), 32'h0);
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0001, 4'b0000, 0);
        cyc(0, 4'b0000, 4'b0001, 0);
        chk("gerr_disabled", 32'(grant_err), 32'h1);
        chk("gerr_disabled_pend", 32'(pending), 32'h001);

        // Starvation on channel 3 with a disabled stretch in the middle
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0000, 4'b0000, 1);
        cyc(0, 4'b1000, 4'b0000, 1);
        for (int k = 0; k < 8; k++) cyc(0, 4'b0000, 4'b0000, 1);
        cyc(0, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 5; k++) cyc(0, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0000, 4'b0000, 1);
        for (int k = 0; k < 6; k++) cyc(0, 4'b0000, 4'b0000, 1);
        chk("starve_not_yet", 32'(starve), 32'h0);
        cyc(0, 4'b0000, 4'b0000, 1);
        chk("starve_set", 32'(starve), 32'h8);

        // Reset mid-operation
        cyc(1, 4'b0000, 4'b0000, 0);
        cyc(0, 4'b0011, 4'b0000, 1);
        cyc(0, 4'b0011, 4'b0000, 1);
        cyc(0, 4'b0001, 4'b0001, 1);
        cyc(0, 4'b0001, 4'b0000, 1);
        chk("mid_pend", 32'(pending), 32'h013);
        chk("mid_served", 32'(served), 32'd1);
        cyc(1, 4'b0011, 4'b0001, 1);
        chk("mid_rst_req", 32'(req), 32'h0);
        chk("mid_rst_pend", 32'(pending), 32'h0);
        chk("mid_rst_served", 32'(served), 32'h0);

        // Randomized traffic with only well-formed grants
        cyc(0, 4'b0000, 4'b0000, 1);
        for (int k = 0; k < 400; k++) begin
            q.delete();
            for (int i = 0; i < 4; i++) if (m_cnt[i] > 0) q.push_back(i);
            g = '0;
            if (m_en && q.size() > 0 && $urandom_range(0, 3) != 0)
                g[q[$urandom_range(0, q.size() - 1)]] = 1'b1;
            for (int i = 0; i < 4; i++) j[i] = ($urandom_range(0, 3) == 0);
            cyc(($urandom_range(0, 149) == 0), j, g, ($urandom_range(0, 9) != 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
